// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the imem it feeds.
package imem_loader_pkg;

  localparam int          DEFAULT_DEPTH_WORDS = 16384;
  localparam int          DEFAULT_ADDR_W      = 14;
  localparam logic [31:0] NOP_WORD            = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader, bundled as one interface.
interface imem_loader_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes into little-endian 32-bit words; word is complete on the 4th byte.
module imem_loader_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0] lane;
  logic [7:0] b0, b1, b2;

  // The 4th byte is used straight from the input so the word is usable on its accept edge.
  assign word_valid = byte_valid && (lane == 2'd3);
  assign word       = {byte_data, b2, b1, b0};

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      lane <= 2'd0;
      b0   <= 8'h00;
      b1   <= 8'h00;
      b2   <= 8'h00;
    end else if (byte_valid) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    b0 <= byte_data;
        2'd1:    b1 <= byte_data;
        2'd2:    b2 <= byte_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a counted little-endian word stream into imem while holding the core in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int          ADDR_W      = DEFAULT_ADDR_W,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            err_overflow,
  output logic [ADDR_W:0] words_loaded
);

  state_t          state;
  logic            in_ready;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [ADDR_W:0] count;
  logic            start_take;
  logic            byte_take;
  logic            word_valid;
  logic [31:0]     word;

  assign start_take = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign byte_take  = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_take),
    .byte_valid (byte_take),
    .byte_data  (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= 32'h0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      words_loaded <= '0;
      count        <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_HDR;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            words_loaded <= '0;
            count        <= '0;
          end
        end
        ST_HDR: begin
          if (word_valid) begin
            if (word == 32'h0) begin
              state    <= ST_DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else if (word > 32'(DEPTH_WORDS)) begin
              state        <= ST_ERR;
              in_ready     <= 1'b0;
              busy         <= 1'b0;
              err_overflow <= 1'b1;
            end else begin
              state <= ST_LOAD;
              count <= word[ADDR_W:0];
            end
          end
        end
        ST_LOAD: begin
          // words_loaded already counts the word being written, so equality marks the last write.
          if (mem_we && words_loaded == count) begin
            state    <= ST_DONE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else if (word_valid) begin
            mem_we       <= 1'b1;
            mem_wdata    <= word;
            mem_addr     <= BASE_ADDR + (32'(words_loaded) << 2);
            words_loaded <= words_loaded + (ADDR_W + 1)'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes are queued as words are issued.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam logic [31:0] BASE  = 32'h0;
  localparam int          AW    = DEFAULT_ADDR_W;
  localparam int          DEPTH = DEFAULT_DEPTH_WORDS;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cpu_hold, busy, done, err_overflow;
  logic [AW:0] words_loaded;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  imem_loader_if bus ();

  imem_loader #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_W      (AW),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err_overflow (err_overflow),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check_output("write addr", bus.mem_addr, e.addr);
        check_output("write data", bus.mem_wdata, e.data);
        check_output("words_loaded at write", 32'(words_loaded), 32'(e.idx + 1));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check_output({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
    check_output({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
    check_output({tag, " mem_addr"}, bus.mem_addr, BASE);
    check_output({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
    check_output({tag, " cpu_hold"}, 32'(cpu_hold), 32'd0);
    check_output({tag, " busy"}, 32'(busy), 32'd0);
    check_output({tag, " done"}, 32'(done), 32'd0);
    check_output({tag, " err_overflow"}, 32'(err_overflow), 32'd0);
    check_output({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte and returns just after the edge on which it is accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL byte accept timeout: got in_ready=0 for 50 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [31:0] w, input bit gaps);
    logic [31:0] v;
    v = w;
    for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], gaps);
  endtask

  task automatic wait_finish();
    int guard;
    guard = 0;
    while (done !== 1'b1 && err_overflow !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL session end timeout: got done=%0b err=%0b, expected one set", done, err_overflow);
    end
  endtask

  // Reference behaviour: word i of the stream lands at BASE + 4*i, in stream order.
  task automatic run_session(input int n, input bit gaps, input bit poke_start);
    logic [31:0] w;
    pulse_start();
    check_output("session cpu_hold after start", 32'(cpu_hold), 32'd1);
    check_output("session busy after start", 32'(busy), 32'd1);
    check_output("session err cleared", 32'(err_overflow), 32'd0);
    check_output("session done cleared", 32'(done), 32'd0);
    apply_stimulus(32'(n), gaps);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      exp_q.push_back('{addr: BASE + 32'(4 * i), data: w, idx: i});
      apply_stimulus(w, gaps);
      if (poke_start && i == 0) pulse_start();
    end
    wait_finish();
    check_output("session done", 32'(done), 32'd1);
    check_output("session err", 32'(err_overflow), 32'd0);
    check_output("session cpu_hold released", 32'(cpu_hold), 32'd0);
    check_output("session busy", 32'(busy), 32'd0);
    check_output("session in_ready", 32'(bus.in_ready), 32'd0);
    check_output("session words_loaded", 32'(words_loaded), 32'(n));
    check_output("session pending writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by 500us, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] w;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("idle");

    // Single word DEADBEEF, checked cycle by cycle.
    pulse_start();
    apply_stimulus(32'd1, 1'b0);
    exp_q.push_back('{addr: BASE, data: 32'hDEADBEEF, idx: 0});
    apply_stimulus(32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check_output("single busy during write", 32'(busy), 32'd1);
    @(negedge clk);
    check_output("single done timing", 32'(done), 32'd1);
    check_output("single cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("single words_loaded", 32'(words_loaded), 32'd1);
    check_output("single pending", 32'(exp_q.size()), 32'd0);

    // Three words with random gaps.
    run_session(3, 1'b1, 1'b0);

    // Empty image finishes straight after the header.
    pulse_start();
    apply_stimulus(32'd0, 1'b0);
    @(negedge clk);
    check_output("empty done timing", 32'(done), 32'd1);
    check_output("empty cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("empty words_loaded", 32'(words_loaded), 32'd0);

    // Oversized header.
    pulse_start();
    apply_stimulus(32'(DEPTH + 1), 1'b1);
    @(negedge clk);
    check_output("overflow err", 32'(err_overflow), 32'd1);
    check_output("overflow in_ready", 32'(bus.in_ready), 32'd0);
    check_output("overflow cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("overflow done", 32'(done), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output("overflow byte refused", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    run_session(2, 1'b1, 1'b0);

    // Reset part-way through the second word.
    pulse_start();
    apply_stimulus(32'd3, 1'b0);
    w = $urandom;
    exp_q.push_back('{addr: BASE, data: w, idx: 0});
    apply_stimulus(w, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("mid-load reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("mid-load pending", 32'(exp_q.size()), 32'd0);

    // Bytes offered while idle are left on the link.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output("idle byte refused", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;

    // Start pulsed mid-load must not disturb the stream.
    run_session(3, 1'b1, 1'b1);

    for (int s = 0; s < 4; s++) run_session(int'($urandom_range(1, 6)), bit'($urandom_range(0, 1)), 1'b0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
